hb_watchdog: RTL and testbench

HB_WATCHDOG -- requirements
Module: hb_watchdog

---
 rtl/hb_watchdog.sv | 166 ++++++++++++++++
 tb/tb_hb_watchdog.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : hb_watchdog
// Description : Heartbeat watchdog. Watches a debounced "alive" flag, pulses
//               an active-low reset to the monitored host when the heartbeat
//               is lost, retries a bounded number of times, then latches
//               FAULT until cleared. One shared timer measures time-in-state.
//               Optional build macro HB_WDT_EVENT_CNT_EN enables the
//               saturating loss-event counter on loss_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module hb_watchdog #(
    parameter int COUNT_WIDTH = 12,
    parameter int LOSS_HOLD   = 16,
    parameter int RST_PULSE   = 32,
    parameter int RECOVER_MAX = 200,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       alive,
    input  logic       enable,
    input  logic       clr_fault,
    output logic       host_rst_l,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        ST_RECOVER   = 3'd0,
        ST_MONITOR   = 3'd1,
        ST_DEBOUNCE  = 3'd2,
        ST_RESETTING = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // The MONITOR sample is loss sample 1, so DEBOUNCE timer value k is
    // loss sample k+2; LOSS_HOLD==1 never enters DEBOUNCE at all.
    localparam int                     c_loss_last_i  = (LOSS_HOLD >= 2) ? (LOSS_HOLD - 2) : 0;
    localparam logic [COUNT_WIDTH-1:0] c_recover_last = COUNT_WIDTH'(RECOVER_MAX - 1);
    localparam logic [COUNT_WIDTH-1:0] c_pulse_last   = COUNT_WIDTH'(RST_PULSE - 1);
    localparam logic [COUNT_WIDTH-1:0] c_loss_last    = COUNT_WIDTH'(c_loss_last_i);
    localparam logic [COUNT_WIDTH-1:0] c_one          = COUNT_WIDTH'(1);
    localparam logic [1:0]             c_max_retry    = 2'(MAX_RETRY);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] timer_q, timer_d;
    logic [1:0]             retry_q, retry_d;
    logic                   host_rst_l_q, host_rst_l_d;
    logic                   fault_q, fault_d;

    logic                   w_timeout;
    logic [1:0]             w_retry_base;

    // Next-state decode: enable gate, per-state events, then the shared
    // timeout path which sees retry_cnt after any same-cycle clear.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + c_one;
        w_timeout    = 1'b0;
        w_retry_base = clr_fault ? 2'd0 : retry_q;
        retry_d      = w_retry_base;

        if (!enable) begin
            state_d = ST_RECOVER;
        end else begin
            case (state_q)
                ST_RECOVER: begin
                    if (alive)
                        state_d = ST_MONITOR;
                    else if (timer_q == c_recover_last)
                        w_timeout = 1'b1;
                end
                ST_MONITOR: begin
                    if (!alive) begin
                        if (LOSS_HOLD == 1)
                            w_timeout = 1'b1;
                        else
                            state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (alive)
                        state_d = ST_MONITOR;
                    else if (timer_q == c_loss_last)
                        w_timeout = 1'b1;
                end
                ST_RESETTING: begin
                    if (timer_q == c_pulse_last)
                        state_d = ST_RECOVER;
                end
                ST_FAULT: begin
                    if (clr_fault)
                        state_d = ST_RECOVER;
                end
                default: state_d = ST_RECOVER;
            endcase

            if (w_timeout) begin
                if (w_retry_base == c_max_retry) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_RESETTING;
                    retry_d = w_retry_base + 2'd1;
                end
            end
        end

        // Timer restarts on any state change and is parked at 0 while disabled.
        if (!enable || (state_d != state_q))
            timer_d = '0;

        host_rst_l_d = (state_d != ST_RESETTING);
        fault_d      = (state_d == ST_FAULT);
    end

    // FSM registers; outputs are registered from the next state so they
    // change only on clock edges (or immediately on reset).
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_RECOVER;
            timer_q      <= '0;
            retry_q      <= 2'd0;
            host_rst_l_q <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            host_rst_l_q <= host_rst_l_d;
            fault_q      <= fault_d;
        end
    end

`ifdef HB_WDT_EVENT_CNT_EN
    logic [7:0] loss_q, loss_d;
    logic       w_loss_evt;

    // A loss event is the LOSS_HOLD-th consecutive low sample being taken.
    assign w_loss_evt = enable && !alive &&
                        (((state_q == ST_DEBOUNCE) && (timer_q == c_loss_last)) ||
                         ((state_q == ST_MONITOR) && (LOSS_HOLD == 1)));
    assign loss_d     = (w_loss_evt && (loss_q != 8'hFF)) ? (loss_q + 8'd1) : loss_q;

    // Saturating loss-event counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            loss_q <= 8'h00;
        else
            loss_q <= loss_d;
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'h00;
`endif

    assign state      = state_q;
    assign retry_cnt  = retry_q;
    assign host_rst_l = host_rst_l_q;
    assign fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_hb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : tb_hb_watchdog
// Description : Self-checking bench for hb_watchdog. A behavioural model that
//               tracks consecutive-low runs and elapsed time per phase is
//               compared against the DUT every cycle, plus directed scenario
//               checks and a randomized heartbeat phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hb_watchdog;

    localparam int COUNT_WIDTH = 12;
    localparam int LOSS_HOLD   = 16;
    localparam int RST_PULSE   = 32;
    localparam int RECOVER_MAX = 200;
    localparam int MAX_RETRY   = 3;

    localparam int P_REC = 0, P_MON = 1, P_DEB = 2, P_RES = 3, P_FLT = 4;

`ifdef HB_WDT_EVENT_CNT_EN
    localparam int EXP_LOSS3 = 3;
`else
    localparam int EXP_LOSS3 = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       alive = 1'b0;
    logic       enable = 1'b1;
    logic       clr_fault = 1'b0;
    logic       host_rst_l;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int m_phase, m_retry, m_loss, m_elapsed, m_low_run;

    hb_watchdog #(
        .COUNT_WIDTH(COUNT_WIDTH),
        .LOSS_HOLD  (LOSS_HOLD),
        .RST_PULSE  (RST_PULSE),
        .RECOVER_MAX(RECOVER_MAX),
        .MAX_RETRY  (MAX_RETRY)
    ) u_dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .alive     (alive),
        .enable    (enable),
        .clr_fault (clr_fault),
        .host_rst_l(host_rst_l),
        .fault     (fault),
        .state     (state),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_REC;
        m_retry   = 0;
        m_loss    = 0;
        m_elapsed = 0;
        m_low_run = 0;
    endtask

    // One clock of the watchdog rules, in terms of elapsed time and low runs.
    task automatic model_step(input logic a, input logic en, input logic clr);
        int  nxt;
        int  r;
        bit  to;
        bit  lost;
        r    = clr ? 0 : m_retry;
        nxt  = m_phase;
        to   = 0;
        lost = 0;
        if (!en) begin
            m_phase   = P_REC;
            m_elapsed = 0;
            m_retry   = r;
            m_low_run = 0;
            return;
        end
        case (m_phase)
            P_REC: if (a) nxt = P_MON; else if (m_elapsed + 1 >= RECOVER_MAX) to = 1;
            P_MON: if (!a) begin
                m_low_run = 1;
                if (m_low_run >= LOSS_HOLD) begin to = 1; lost = 1; end
                else nxt = P_DEB;
            end
            P_DEB: if (a) nxt = P_MON;
                   else begin
                       m_low_run++;
                       if (m_low_run >= LOSS_HOLD) begin to = 1; lost = 1; end
                   end
            P_RES: if (m_elapsed + 1 >= RST_PULSE) nxt = P_REC;
            default: if (clr) nxt = P_REC;
        endcase
        if (to) begin
            if (r == MAX_RETRY) nxt = P_FLT;
            else begin nxt = P_RES; r = r + 1; end
        end
`ifdef HB_WDT_EVENT_CNT_EN
        if (lost && m_loss < 255) m_loss++;
`endif
        m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
        m_phase   = nxt;
        m_retry   = r;
    endtask

    // Advance one clock, update the model, then compare outputs after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_l) model_reset();
        else model_step(alive, enable, clr_fault);
        #1;
        check_val("state", 32'(state), 32'(m_phase));
        check_val("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        check_val("host_rst_l", 32'(host_rst_l), 32'(m_phase != P_RES));
        check_val("fault", 32'(fault), 32'(m_phase == P_FLT));
        check_val("loss_cnt", 32'(loss_cnt), 32'(m_loss));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        int lows;
        int run_left;
        model_reset();

        // Reset state
        ticks(3);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_host", 32'(host_rst_l), 32'd1);

        // Release, alive returns after 5 cycles -> MONITOR
        rst_l = 1'b1;
        ticks(5);
        alive = 1'b1;
        tick();
        check_val("mon_entry", 32'(state), 32'(P_MON));
        check_val("mon_retry", 32'(retry_cnt), 32'd0);

        // 15 low samples: no loss
        alive = 1'b0;
        ticks(15);
        alive = 1'b1;
        tick();
        check_val("deb15_state", 32'(state), 32'(P_MON));
        check_val("deb15_host", 32'(host_rst_l), 32'd1);

        // 16 low samples: one 32-cycle pulse
        alive = 1'b0;
        lows  = 0;
        for (int i = 0; i < 16 + 40; i++) begin
            tick();
            if (host_rst_l == 1'b0) lows++;
        end
        check_val("pulse_width", 32'(lows), 32'(RST_PULSE));
        check_val("pulse_retry", 32'(retry_cnt), 32'd1);
        check_val("pulse_rec", 32'(state), 32'(P_REC));
        alive = 1'b1;
        tick();
        check_val("pulse_mon", 32'(state), 32'(P_MON));

        // Stuck low after reset -> FAULT after three retries
        rst_l = 1'b0;
        alive = 1'b0;
        ticks(2);
        rst_l = 1'b1;
        n = 0;
        while (state != 3'(P_FLT) && n < 2000) begin
            tick();
            n++;
        end
        check_val("fault_time", 32'(n), 32'(4 * RECOVER_MAX + 3 * RST_PULSE));
        check_val("fault_flag", 32'(fault), 32'd1);
        check_val("fault_retry", 32'(retry_cnt), 32'(MAX_RETRY));
        ticks(10);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check_val("clr_state", 32'(state), 32'(P_REC));
        check_val("clr_fault", 32'(fault), 32'd0);
        check_val("clr_retry", 32'(retry_cnt), 32'd0);

        // Three debounce losses
        for (int k = 0; k < 3; k++) begin
            alive = 1'b1;
            tick();
            alive = 1'b0;
            ticks(16 + RST_PULSE + 3);
        end
        alive = 1'b1;
        tick();
        check_val("loss3", 32'(loss_cnt), 32'(EXP_LOSS3));
        check_val("loss3_retry", 32'(retry_cnt), 32'd3);

        // Clear coinciding with timeout uses retry 0
        alive = 1'b0;
        ticks(LOSS_HOLD - 1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check_val("clr_to_state", 32'(state), 32'(P_RES));
        check_val("clr_to_retry", 32'(retry_cnt), 32'd1);

        // enable=0 aborts the pulse and suppresses timeouts
        ticks(5);
        enable = 1'b0;
        tick();
        check_val("abort_state", 32'(state), 32'(P_REC));
        check_val("abort_host", 32'(host_rst_l), 32'd1);
        ticks(RECOVER_MAX + 50);
        check_val("dis_state", 32'(state), 32'(P_REC));
        check_val("dis_retry", 32'(retry_cnt), 32'd1);
        enable = 1'b1;
        tick();
        alive = 1'b1;
        tick();
        check_val("reen_mon", 32'(state), 32'(P_MON));

        // Asynchronous reset in the middle of a pulse
        alive = 1'b0;
        ticks(LOSS_HOLD + 9);
        check_val("pre_arst_host", 32'(host_rst_l), 32'd0);
        #2;
        rst_l = 1'b0;
        #1;
        check_val("arst_host", 32'(host_rst_l), 32'd1);
        check_val("arst_state", 32'(state), 32'd0);
        check_val("arst_retry", 32'(retry_cnt), 32'd0);
        check_val("arst_loss", 32'(loss_cnt), 32'd0);
        model_reset();
        tick();
        rst_l = 1'b1;

        // Randomized heartbeat bursts with occasional disable and clear
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                alive    = ~alive;
                run_left = $urandom_range(1, 24);
            end
            run_left--;
            enable    = ($urandom_range(0, 99) != 0);
            clr_fault = ($urandom_range(0, 59) == 0);
            tick();
        end
        clr_fault = 1'b0;
        enable    = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
